// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 types, default widths and read-arbiter FSM encodings
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational round-robin pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       gnt
);

  // ptr only matters on a tie; a lone requester always wins
  assign valid = |req;
  assign gnt   = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master to one-slave AXI3 read arbiter, one outstanding burst
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic [3:0]        m0_arcache,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [ID_W-1:0]   m0_rid,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,

  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic [3:0]        m1_arcache,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ID_W-1:0]   m1_rid,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,

  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic [3:0]        s_arcache,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,

  output logic              err_rlast
);

  logic [1:0]       state;
  logic             ptr;
  logic             grant;
  logic [LEN_W-1:0] cnt;
  logic             pick_valid;
  logic             pick;
  logic             in_idle;
  logic             in_data;
  logic             r_hs;

  rr_arb2 u_rr (
    .req   ({m1_arvalid, m0_arvalid}),
    .ptr   (ptr),
    .valid (pick_valid),
    .gnt   (pick)
  );

  assign in_idle = (state == ST_IDLE);
  assign in_data = (state == ST_DATA);

  // aresetn gating keeps the accept pulse low while reset is held
  assign m0_arready = aresetn & in_idle & pick_valid & ~pick;
  assign m1_arready = aresetn & in_idle & pick_valid &  pick;

  assign m0_rvalid = in_data & ~grant & s_rvalid;
  assign m1_rvalid = in_data &  grant & s_rvalid;
  assign s_rready  = in_data & (grant ? m1_rready : m0_rready);
  assign r_hs      = s_rvalid & s_rready;

  assign m0_rdata = s_rdata;
  assign m0_rid   = s_rid;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rdata = s_rdata;
  assign m1_rid   = s_rid;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      grant     <= 1'b0;
      cnt       <= '0;
      err_rlast <= 1'b0;
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
      s_arid    <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
      s_arcache <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            s_arvalid <= 1'b1;
            s_araddr  <= pick ? m1_araddr  : m0_araddr;
            s_arid    <= pick ? m1_arid    : m0_arid;
            s_arlen   <= pick ? m1_arlen   : m0_arlen;
            s_arsize  <= pick ? m1_arsize  : m0_arsize;
            s_arburst <= pick ? m1_arburst : m0_arburst;
            s_arcache <= pick ? m1_arcache : m0_arcache;
            cnt       <= '0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            if (cnt != {LEN_W{1'b1}}) cnt <= cnt + 1'b1;
            // s_arlen still holds the granted length for the whole burst
            if ((cnt == s_arlen && !s_rlast) || (cnt < s_arlen && s_rlast))
              err_rlast <= 1'b1;
            if (s_rlast) begin
              state <= ST_IDLE;
              ptr   <= ~grant;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master to one-slave AXI3 read-channel arbiter sitting between two master agents and the shared `axi_slave` memory model. Accepts one AR request at a time with round-robin fairness, forwards it to the slave, and routes the R burst back to the granted master until `rlast`. Only one read transaction is outstanding at any time. Beat counting checks `rlast` placement against the granted `arlen`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, read data width
- `ID_W`, 4, transaction ID width
- `LEN_W`, 4, burst length field width (AXI3, 1–16 beats)

Ports. Clock and reset:
- `aclk`  in  1  single clock; all logic on rising edge
- `aresetn`  in  1  asynchronous, active-low reset

Master-side AR ports, one set each for `m0_` and `m1_`:
- `mN_arvalid`  in  1  request
- `mN_arready`  out  1  accept pulse
- `mN_araddr`  in  ADDR_W  address
- `mN_arid`  in  ID_W  ID
- `mN_arlen`  in  LEN_W  length
- `mN_arsize`  in  3  size
- `mN_arburst`  in  2  burst type
- `mN_arcache`  in  4  cache attributes

Master-side R ports, one set each for `m0_` and `m1_`:
- `mN_rvalid`  out  1  beat valid
- `mN_rready`  in  1  beat ready
- `mN_rdata`  out  DATA_W  data
- `mN_rid`  out  ID_W  ID
- `mN_rresp`  out  2  response
- `mN_rlast`  out  1  last beat

Slave side, with the same fields prefixed `s_` and directions reversed:
- `s_arvalid/araddr/arid/arlen/arsize/arburst/arcache`  out  AR channel
- `s_arready`  in  1  AR accept
- `s_rvalid/rdata/rid/rresp/rlast`  in  R channel
- `s_rready`  out  1  R ready

Status:
- `err_rlast`  out  1  sticky; set on an `rlast` mismatch and cleared only by reset

## Operation
- The FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any `mN_arvalid` is high, the round-robin pick selects grant G.
  - The arbiter pulses `mG_arready` for exactly one cycle, registers the AR payload and `arlen`, clears the beat counter, and moves to ADDR.
  - With no request, it stays in IDLE.
- ADDR:
  - `s_arvalid`=1 with the registered payload.
  - On `s_arready`=1, the arbiter moves to DATA.
  - `s_arvalid` and the payload stay stable until the handshake.
- DATA:
  - `mG_rvalid` = `s_rvalid`, and `s_rready` = `mG_rready` (combinational pass-through).
  - The non-granted master's `rvalid` is 0.
  - `rdata/rid/rresp/rlast` are broadcast to both masters.
- Beat counting:
  - The counter increments on each `s_rvalid & s_rready`.
  - On a handshake with `s_rlast`=1, the arbiter returns to IDLE and sets the priority pointer to the master that was not G.
- Round robin:
  - The pointer names the preferred master.
  - On a simultaneous request from both masters, the preferred master wins.
  - A single requester always wins regardless of the pointer.
- rlast check, on each R handshake:
  - `err_rlast` is set if count==`arlen` and `s_rlast`=0.
  - `err_rlast` is set if count<`arlen` and `s_rlast`=1.
  - Termination is governed only by `s_rlast`; the counter saturates at 2^LEN_W−1.
- `arid` passes through unmodified, and `rid` is not used for routing. Routing uses only the registered grant.

## Timing
- Reset values: state IDLE; pointer=0 (m0 preferred); grant=0; counter=0; `err_rlast`=0.
  - The arready outputs `m0_arready`, `m1_arready` are 0.
  - The registered AR outputs `s_arvalid`, `s_araddr`, `s_arid`, `s_arlen`, `s_arsize`, `s_arburst`, `s_arcache` are 0.
  - Outside DATA, the R-path handshake outputs `m0_rvalid`, `m1_rvalid`, `s_rready` are 0.
  - The broadcast R payload `mN_rdata/rid/rresp/rlast` always follows the corresponding `s_r*` inputs, so it has no fixed reset value.
- Latency: `s_arvalid` rises 1 cycle after the `mG_arready` pulse. R beats pass with 0 cycles of latency.
- Back-to-back transactions: the cycle after the final R handshake is IDLE. The next `arready` pulse can occur in that cycle, giving a minimum of 1 idle cycle between bursts.
- Reset mid-operation: the asynchronous reset drops all outputs immediately and returns the FSM to IDLE. Any in-flight burst is abandoned.
- A master deasserting `arvalid` in IDLE before the pulse is never granted. `arready` is only asserted in IDLE.

## Structure
- Shared package `axi_pkg`:
  - burst enum FIXED=0, INCR=1, WRAP=2
  - resp enum OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
  - default widths
  - FSM state enum
- Sub-module `rr_arb2`: 2-way combinational round-robin pick from the request vector and pointer. The pointer register is held in the parent.

## Test plan
- Single read: m0 sends araddr=0x100, arlen=3. Expect `s_arvalid` 1 cycle after `m0_arready`; 4 beats routed to m0 only; `m1_rvalid`=0 throughout; `err_rlast`=0.
- Contention: m0 and m1 request in the same cycle after reset. m0 is granted first; m1 is granted on the first IDLE cycle after m0's rlast.
- Fairness: both masters hold arvalid for 6 transactions. Grants alternate m0, m1, m0, m1, m0, m1.
- Backpressure: `s_arready` is held 0 for 5 cycles, and `m1_rready` toggles every cycle during a 4-beat burst. The AR payload stays stable while waiting, and exactly 4 handshakes occur.
- rlast error: arlen=3 with the slave asserting rlast on beat 2 (count 1). `err_rlast`=1, the FSM returns to IDLE, and `err_rlast` stays set.
- Reset mid-burst: `aresetn` is pulled low after beat 1 of an 8-beat burst. All outputs go to reset values immediately, and a new read after release completes normally.
